i2c_reg_sequencer: RTL

//  Transaction sequencer for the camera-config I2C master register port. Accepts
//  one register write or read request (7-bit device, 8-bit register, 8-bit data),

---
 rtl/i2c_reg_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_sequencer
// Description : Runs one register write/read on the I2C master register port:
//               issues commands, polls master busy, checks ACK, returns data.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_sequencer #(
    parameter logic SPEED_400K  = 1'b0,
    parameter int   TIMEOUT_CYC = 1048575,
    parameter int   TO_W        = 20
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Req,
    input  logic       Rw,
    input  logic [6:0] DevAddr,
    input  logic [7:0] RegAddr,
    input  logic [7:0] WrData,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [7:0] RdData,
    output logic [2:0] M_Addr,
    output logic [7:0] M_DataWr,
    input  logic [7:0] M_DataRd,
    output logic       M_En,
    output logic       M_Wr,
    output logic       M_Rd
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ISSUE  = 3'd1;
    localparam logic [2:0] c_ARM    = 3'd2;
    localparam logic [2:0] c_POLL   = 3'd3;
    localparam logic [2:0] c_ACKCHK = 3'd4;
    localparam logic [2:0] c_RDDAT  = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    localparam logic [2:0] c_CMD_START = 3'd0;
    localparam logic [2:0] c_CMD_STOP  = 3'd1;
    localparam logic [2:0] c_CMD_READ  = 3'd2;
    localparam logic [2:0] c_CMD_WRITE = 3'd3;
    localparam logic [2:0] c_REG_SPEED = 3'd4;
    localparam logic [2:0] c_REG_STAT  = 3'd4;
    localparam logic [2:0] c_REG_RXD   = 3'd3;

    localparam logic [3:0] c_STEP_SPD   = 4'd0;
    localparam logic [3:0] c_STEP_FIRST = 4'd1;
    localparam logic [3:0] c_STOP_WR    = 4'd5;
    localparam logic [3:0] c_STOP_RD    = 4'd7;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [2:0]      state_q,    state_d;
    logic [3:0]      step_q,     step_d;
    logic            err_q,      err_d;
    logic            spd_done_q, spd_done_d;
    logic [TO_W-1:0] to_cnt_q,   to_cnt_d;
    logic            rw_q,       rw_d;
    logic [6:0]      dev_q,      dev_d;
    logic [7:0]      reg_q,      reg_d;
    logic [7:0]      wdat_q,     wdat_d;
    logic [7:0]      rdata_q,    rdata_d;

    logic [2:0]      w_cmd_addr;
    logic [7:0]      w_cmd_data;
    logic [3:0]      w_stop_step;
    logic            w_m_busy;
    logic            w_m_nack;

    assign w_m_busy    = M_DataRd[0];
    assign w_m_nack    = M_DataRd[2];
    assign w_stop_step = rw_q ? c_STOP_RD : c_STOP_WR;

    // Command script: step 0 is the one-shot speed setup, the rest is the bus sequence.
    always_comb begin
        w_cmd_addr = c_CMD_STOP;
        w_cmd_data = 8'h00;
        case (step_q)
            4'd0: begin
                w_cmd_addr = c_REG_SPEED;
                w_cmd_data = {7'b0, SPEED_400K};
            end
            4'd1: w_cmd_addr = c_CMD_START;
            4'd2: begin
                w_cmd_addr = c_CMD_WRITE;
                w_cmd_data = {dev_q, 1'b0};
            end
            4'd3: begin
                w_cmd_addr = c_CMD_WRITE;
                w_cmd_data = reg_q;
            end
            4'd4: begin
                if (rw_q) begin
                    w_cmd_addr = c_CMD_START;
                end else begin
                    w_cmd_addr = c_CMD_WRITE;
                    w_cmd_data = wdat_q;
                end
            end
            4'd5: begin
                if (rw_q) begin
                    w_cmd_addr = c_CMD_WRITE;
                    w_cmd_data = {dev_q, 1'b1};
                end else begin
                    w_cmd_addr = c_CMD_STOP;
                end
            end
            4'd6:    w_cmd_addr = c_CMD_READ;
            default: w_cmd_addr = c_CMD_STOP;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= c_IDLE;
            step_q     <= 4'd0;
            err_q      <= 1'b0;
            spd_done_q <= 1'b0;
            to_cnt_q   <= '0;
            rw_q       <= 1'b0;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            wdat_q     <= 8'h00;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            err_q      <= err_d;
            spd_done_q <= spd_done_d;
            to_cnt_q   <= to_cnt_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdat_q     <= wdat_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        err_d      = err_q;
        spd_done_d = spd_done_q;
        to_cnt_d   = to_cnt_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdat_d     = wdat_q;
        rdata_d    = rdata_q;
        case (state_q)
            c_IDLE: begin
                if (Req) begin
                    rw_d    = Rw;
                    dev_d   = DevAddr;
                    reg_d   = RegAddr;
                    wdat_d  = WrData;
                    err_d   = 1'b0;
                    step_d  = spd_done_q ? c_STEP_FIRST : c_STEP_SPD;
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (step_q == c_STEP_SPD) begin
                    spd_done_d = 1'b1;
                end
                state_d = c_ARM;
            end
            c_ARM: begin
                to_cnt_d = '0;
                state_d  = c_POLL;
            end
            c_POLL: begin
                if (w_m_busy) begin
                    // Abort without STOP: the master may still be holding the bus.
                    if (to_cnt_q == c_TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = c_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else if (step_q != c_STEP_SPD && w_cmd_addr == c_CMD_WRITE) begin
                    state_d = c_ACKCHK;
                end else if (step_q == w_stop_step) begin
                    state_d = (rw_q && !err_q) ? c_RDDAT : c_DONE;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = c_ISSUE;
                end
            end
            c_ACKCHK: begin
                if (w_m_nack) begin
                    err_d  = 1'b1;
                    step_d = w_stop_step;
                end else begin
                    step_d = step_q + 4'd1;
                end
                state_d = c_ISSUE;
            end
            c_RDDAT: begin
                rdata_d = M_DataRd;
                state_d = c_DONE;
            end
            c_DONE: begin
                err_d   = 1'b0;
                step_d  = 4'd0;
                state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        Busy     = 1'b0;
        Done     = 1'b0;
        Err      = 1'b0;
        M_Addr   = 3'd0;
        M_DataWr = 8'h00;
        M_En     = 1'b0;
        M_Wr     = 1'b0;
        M_Rd     = 1'b0;
        case (state_q)
            c_ISSUE: begin
                Busy     = 1'b1;
                M_En     = 1'b1;
                M_Wr     = 1'b1;
                M_Addr   = w_cmd_addr;
                M_DataWr = w_cmd_data;
            end
            c_ARM: Busy = 1'b1;
            c_POLL, c_ACKCHK: begin
                Busy   = 1'b1;
                M_En   = 1'b1;
                M_Rd   = 1'b1;
                M_Addr = c_REG_STAT;
            end
            c_RDDAT: begin
                Busy   = 1'b1;
                M_En   = 1'b1;
                M_Rd   = 1'b1;
                M_Addr = c_REG_RXD;
            end
            c_DONE: begin
                Done = 1'b1;
                Err  = err_q;
            end
            default: Busy = 1'b0;
        endcase
    end

    assign RdData = rdata_q;

endmodule
`default_nettype wire
